// File: rtl/y86_decode_regfile.sv
// Y86 decode stage: register file with dual write-back and same-cycle bypass,
// followed by a valid/ready output slot. Define REGFILE_DEBUG_PORT_EN for a raw array read port.
module y86_decode_regfile #(
  parameter int               WIDTH    = 64,
  parameter int               NREGS    = 15,
  parameter int               RSP_IDX  = 4,
  parameter logic [WIDTH-1:0] RESET_SP = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic             wE_en,
  input  logic [3:0]       wE_dst,
  input  logic [WIDTH-1:0] valE,
  input  logic             wM_en,
  input  logic [3:0]       wM_dst,
  input  logic [WIDTH-1:0] valM,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       d_icode,
  output logic [3:0]       d_ifun,
  output logic [WIDTH-1:0] d_valA,
  output logic [WIDTH-1:0] d_valB,
  output logic [3:0]       d_srcA,
  output logic [3:0]       d_srcB,
  output logic [3:0]       d_dstE,
  output logic [3:0]       d_dstM
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
`endif
);

  localparam logic [3:0] NONE = 4'hF;
  localparam logic [3:0] RSP  = 4'(RSP_IDX);

  logic [WIDTH-1:0] regs [NREGS];

  logic [3:0]       src_a, src_b, dst_e, dst_m;
  logic [WIDTH-1:0] val_a, val_b;
  logic             accept;

  function automatic logic in_range(input logic [3:0] idx);
    return (idx != NONE) && (int'(idx) < NREGS);
  endfunction

  // M is applied after E so it wins when both ports target the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == RSP_IDX) ? RESET_SP : '0;
      end
    end else begin
      if (wE_en && in_range(wE_dst)) begin
        regs[wE_dst] <= valE;
      end
      if (wM_en && in_range(wM_dst)) begin
        regs[wM_dst] <= valM;
      end
    end
  end

  always_comb begin
    src_a = NONE;
    src_b = NONE;
    dst_e = NONE;
    dst_m = NONE;
    case (icode)
      4'h2: begin src_a = ra;  dst_e = rb; end
      4'h3: begin dst_e = rb; end
      4'h4: begin src_a = ra;  src_b = rb; end
      4'h5: begin src_b = rb;  dst_m = ra; end
      4'h6: begin src_a = ra;  src_b = rb;  dst_e = rb; end
      4'h8: begin src_b = RSP; dst_e = RSP; end
      4'h9: begin src_a = RSP; src_b = RSP; dst_e = RSP; end
      4'hA: begin src_a = ra;  src_b = RSP; dst_e = RSP; end
      4'hB: begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = ra; end
      default: ;
    endcase
  end

  // Bypass priority mirrors write priority: M over E over the stored value.
  function automatic logic [WIDTH-1:0] read_bypass(input logic [3:0] idx);
    if (!in_range(idx))            return '0;
    else if (wM_en && wM_dst == idx) return valM;
    else if (wE_en && wE_dst == idx) return valE;
    else                           return regs[idx];
  endfunction

  always_comb begin
    val_a = read_bypass(src_a);
    val_b = read_bypass(src_b);
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      d_icode   <= '0;
      d_ifun    <= '0;
      d_valA    <= '0;
      d_valB    <= '0;
      d_srcA    <= NONE;
      d_srcB    <= NONE;
      d_dstE    <= NONE;
      d_dstM    <= NONE;
    end else if (accept) begin
      out_valid <= 1'b1;
      d_icode   <= icode;
      d_ifun    <= ifun;
      d_valA    <= val_a;
      d_valB    <= val_b;
      d_srcA    <= src_a;
      d_srcB    <= src_b;
      d_dstE    <= dst_e;
      d_dstM    <= dst_m;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef REGFILE_DEBUG_PORT_EN
  assign dbg_data = in_range(dbg_addr) ? regs[dbg_addr] : '0;
`endif

endmodule

// File: tb/tb_y86_decode_regfile.sv
// Self-checking bench for y86_decode_regfile: vector table driven through a
// scoreboard, plus hand sequences for back-pressure and reset mid-stall.
module tb_y86_decode_regfile;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  icode, ifun, ra, rb, wE_dst, wM_dst;
  logic        wE_en, wM_en;
  logic [63:0] valE, valM, d_valA, d_valB;
  logic [3:0]  d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM;

  y86_decode_regfile #(.WIDTH(64), .NREGS(15), .RSP_IDX(4), .RESET_SP(64'h100)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .ra(ra), .rb(rb),
    .wE_en(wE_en), .wE_dst(wE_dst), .valE(valE),
    .wM_en(wM_en), .wM_dst(wM_dst), .valM(valM),
    .out_valid(out_valid), .out_ready(out_ready),
    .d_icode(d_icode), .d_ifun(d_ifun), .d_valA(d_valA), .d_valB(d_valB),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM)
  );

  typedef struct {
    logic        in_valid;
    logic [3:0]  icode, ifun, ra, rb;
    logic        we_en;
    logic [3:0]  we_dst;
    logic [63:0] vale;
    logic        wm_en;
    logic [3:0]  wm_dst;
    logic [63:0] valm;
    logic        out_ready;
    logic [15:0] ids;
  } vec_t;

  typedef struct {
    logic [3:0]  icode, ifun;
    logic [63:0] vala, valb;
    logic [15:0] ids;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] mdl_regs [15];
  logic        mdl_valid;
  exp_t        sb [$];
  vec_t        tbl [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [3:0] ic, input logic [3:0] a,
                              input logic [3:0] b, input logic [15:0] ids, input logic ordy);
    vec_t v;
    v.in_valid = iv;  v.icode = ic;   v.ifun = 4'h0; v.ra = a; v.rb = b;
    v.we_en = 1'b0;   v.we_dst = 4'h0; v.vale = '0;
    v.wm_en = 1'b0;   v.wm_dst = 4'h0; v.valm = '0;
    v.out_ready = ordy; v.ids = ids;
    return v;
  endfunction

  function automatic logic [63:0] mdl_read(input logic [3:0] idx, input vec_t v);
    if (idx >= 4'd15) return '0;
    if (v.wm_en && v.wm_dst == idx) return v.valm;
    if (v.we_en && v.we_dst == idx) return v.vale;
    return mdl_regs[idx];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 15; i++) mdl_regs[i] = (i == 4) ? 64'h100 : 64'h0;
    mdl_valid = 1'b0;
    sb.delete();
  endtask

  task automatic checkReset(input string tag);
    cmp({tag, " out_valid"}, out_valid, 0);
    cmp({tag, " d_icode"}, d_icode, 0);
    cmp({tag, " d_valA"}, d_valA, 0);
    cmp({tag, " d_valB"}, d_valB, 0);
    cmp({tag, " ids"}, {d_srcA, d_srcB, d_dstE, d_dstM}, 16'hFFFF);
  endtask

  task automatic checkOutput();
    cmp("out_valid", out_valid, mdl_valid);
    if (mdl_valid && sb.size() > 0) begin
      cmp("d_icode", d_icode, sb[0].icode);
      cmp("d_ifun", d_ifun, sb[0].ifun);
      cmp("d_valA", d_valA, sb[0].vala);
      cmp("d_valB", d_valB, sb[0].valb);
      cmp("d_ids", {d_srcA, d_srcB, d_dstE, d_dstM}, sb[0].ids);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic ir, fire, consume;
    exp_t e;
    @(negedge clk);
    in_valid = v.in_valid; icode = v.icode; ifun = v.ifun; ra = v.ra; rb = v.rb;
    wE_en = v.we_en; wE_dst = v.we_dst; valE = v.vale;
    wM_en = v.wm_en; wM_dst = v.wm_dst; valM = v.valm;
    out_ready = v.out_ready;
    ir = !mdl_valid || v.out_ready;
    #1;
    cmp("in_ready", in_ready, ir);
    fire    = v.in_valid && ir;
    consume = mdl_valid && v.out_ready;
    if (fire) begin
      e.icode = v.icode; e.ifun = v.ifun; e.ids = v.ids;
      e.vala  = mdl_read(v.ids[15:12], v);
      e.valb  = mdl_read(v.ids[11:8], v);
      sb.push_back(e);
    end
    @(posedge clk);
    if (consume && sb.size() > 0) void'(sb.pop_front());
    if (v.we_en && v.we_dst < 4'd15) mdl_regs[v.we_dst] = v.vale;
    if (v.wm_en && v.wm_dst < 4'd15) mdl_regs[v.wm_dst] = v.valm;
    if (fire) mdl_valid = 1'b1;
    else if (v.out_ready) mdl_valid = 1'b0;
    #1;
    checkOutput();
  endtask

  initial begin
    vec_t t;
    rst_n = 1'b0; in_valid = 0; icode = 0; ifun = 0; ra = 0; rb = 0;
    wE_en = 0; wE_dst = 0; valE = 0; wM_en = 0; wM_dst = 0; valM = 0; out_ready = 1;
    modelReset();

    t = mk(0, 4'h0, 4'h0, 4'h0, 16'hFFFF, 1); t.we_en = 1; t.we_dst = 0; t.vale = 64'h6; tbl.push_back(t);
    tbl.push_back(mk(1, 4'h2, 4'h0, 4'h3, 16'h0F3F, 1));
    t = mk(1, 4'hA, 4'h1, 4'hF, 16'h144F, 1);
    t.we_en = 1; t.we_dst = 4; t.vale = 64'h20; t.wm_en = 1; t.wm_dst = 4; t.valm = 64'h30; tbl.push_back(t);
    tbl.push_back(mk(1, 4'hA, 4'h3, 4'hF, 16'h344F, 1));
    t = mk(1, 4'h3, 4'hF, 4'h5, 16'hFF5F, 1); t.wm_en = 1; t.wm_dst = 1; t.valm = 64'h77; tbl.push_back(t);
    tbl.push_back(mk(1, 4'h5, 4'h2, 4'h1, 16'hF1F2, 1));
    t = mk(1, 4'h6, 4'h0, 4'h1, 16'h011F, 1); t.ifun = 4'h1; t.we_en = 1; t.we_dst = 0; t.vale = 64'h9; tbl.push_back(t);
    tbl.push_back(mk(1, 4'h8, 4'hF, 4'hF, 16'hF44F, 1));
    tbl.push_back(mk(1, 4'h9, 4'hF, 4'hF, 16'h444F, 1));
    tbl.push_back(mk(1, 4'hB, 4'h7, 4'hF, 16'h4447, 1));
    tbl.push_back(mk(1, 4'h7, 4'hF, 4'hF, 16'hFFFF, 1));
    t = mk(1, 4'h1, 4'hF, 4'hF, 16'hFFFF, 1); t.we_en = 1; t.we_dst = 4'hF; t.vale = 64'hDEAD; tbl.push_back(t);
    t = mk(1, 4'h0, 4'hF, 4'hF, 16'hFFFF, 1); t.wm_en = 1; t.wm_dst = 4'hF; t.valm = 64'hBEEF; tbl.push_back(t);
    tbl.push_back(mk(1, 4'hC, 4'h1, 4'h2, 16'hFFFF, 1));
    tbl.push_back(mk(1, 4'hE, 4'h3, 4'h4, 16'hFFFF, 1));
    tbl.push_back(mk(1, 4'h2, 4'h0, 4'h6, 16'h0F6F, 1));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 16'hFFFF, 1));

    repeat (2) @(negedge clk);
    checkReset("reset");
    cmp("reset in_ready", in_ready, 1);
    rst_n = 1'b1;

    foreach (tbl[i]) applyStimulus(tbl[i]);

    // Back-pressure: rmmovq held in the slot while the next instruction waits.
    applyStimulus(mk(1, 4'h4, 4'h2, 4'h1, 16'h21FF, 1));
    for (int i = 0; i < 3; i++) begin
      t = mk(1, 4'h2, 4'h1, 4'h2, 16'h1F2F, 0);
      if (i == 0) begin t.we_en = 1; t.we_dst = 2; t.vale = 64'h55; end
      applyStimulus(t);
    end
    applyStimulus(mk(1, 4'h2, 4'h1, 4'h2, 16'h1F2F, 1));
    applyStimulus(mk(1, 4'h2, 4'h2, 4'h3, 16'h2F3F, 1));
    applyStimulus(mk(0, 4'h0, 4'h0, 4'h0, 16'hFFFF, 1));

    // Reset asserted between edges while the slot is stalled.
    applyStimulus(mk(1, 4'h6, 4'h0, 4'h2, 16'h022F, 1));
    applyStimulus(mk(0, 4'h0, 4'h0, 4'h0, 16'hFFFF, 0));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkReset("async reset");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mk(1, 4'h2, 4'h0, 4'h3, 16'h0F3F, 1));
    applyStimulus(mk(1, 4'hA, 4'h1, 4'hF, 16'h144F, 1));
    applyStimulus(mk(0, 4'h0, 4'h0, 4'h0, 16'hFFFF, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/y86_decode_regfile.md
Name: y86_decode_regfile

Overview:
Parametrised successor to the SEQ decode stage. Holds the Y86 register file and derives srcA/srcB/dstE/dstM from icode/rA/rB. Provides two write-back ports (E and M) with same-cycle bypass. Registers its outputs in a valid/ready pipeline slot, so it serves both the SEQ datapath and the planned PIPE datapath between fetch and execute.

Parameters:
WIDTH, 64, data width of registers and valA/valB/valE/valM
NREGS, 15, number of architectural registers (1..15); index 4'hF always means "none"
RSP_IDX, 4, index of the stack pointer used for push/pop/call/ret
RESET_SP, 0, value loaded into register RSP_IDX on reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  icode/ifun/ra/rb from fetch are valid
in_ready  out  1  stage can accept this cycle
icode  in  4  instruction code
ifun  in  4  function code
ra  in  4  rA field
rb  in  4  rB field
wE_en  in  1  write valE to wE_dst
wE_dst  in  4  E write index
valE  in  WIDTH  E write data
wM_en  in  1  write valM to wM_dst
wM_dst  in  4  M write index
valM  in  WIDTH  M write data
out_valid  out  1  output slot holds a decoded instruction
out_ready  in  1  downstream accepts the slot
d_icode, d_ifun  out  4 each  registered icode/ifun
d_valA, d_valB  out  WIDTH each  registered operands
d_srcA, d_srcB, d_dstE, d_dstM  out  4 each  registered register IDs

Behaviour:
- Reset (async, rst_n=0): all registers cleared to 0, except register RSP_IDX, which is set to RESET_SP. out_valid=0; d_icode, d_ifun, d_valA and d_valB = 0; d_src*/d_dst* = 4'hF.
- srcA: rA for icode 2, 4, 6, A; RSP_IDX for B, 9; else F.
- srcB: rB for icode 4, 5, 6; RSP_IDX for A, B, 8, 9; else F.
- dstE: rB for icode 2, 3, 6; RSP_IDX for A, B, 8, 9; else F. Conditional-move suppression is handled downstream.
- dstM: rA for icode 5, B; else F.
- Read of index F, or of any index >= NREGS, returns 0.
- Writes occur at rising clk when en=1 and dst < NREGS. Writes to F or out of range are ignored.
- Same dst on both ports in one cycle: M wins (popq %rsp semantics).
- Bypass: a read of a register being written in the same cycle returns the new data. M takes priority over E, matching write priority.
- Handshake: in_ready = !out_valid || out_ready.
  - Transfer when in_valid && in_ready: slot loads decoded values, out_valid=1.
  - out_valid && out_ready && !in_valid: out_valid goes to 0 next edge.
  - Stall (out_valid && !out_ready): slot contents held stable. Write-back still updates the array; held d_valA/d_valB are not refreshed.
- Latency: 1 cycle from accepted input to out_valid.
- Illegal icode (>B): decoded with all IDs F, valA=valB=0, passed through. Flagging is fetch's responsibility.
- Reset asserted mid-stall discards the slot.

Optional Feature:
REGFILE_DEBUG_PORT_EN:
- Defined: adds ports dbg_addr (in, 4) and dbg_data (out, WIDTH). dbg_data is a combinational, non-bypassed read of the array; 0 for F or out-of-range.
- Undefined: ports absent, no extra logic.

Test Plan:
1. Reset with RESET_SP=64'h100 -> all regs 0, reg4=0x100, out_valid=0, d_dstE=F.
2. wE_en, dst=0, valE=6; next cycle in icode=2, ra=0, rb=3 -> d_valA=6, d_srcA=0, d_dstE=3, out_valid=1 one cycle after acceptance.
3. Same cycle: wE dst=4 valE=0x20 and wM dst=4 valM=0x30, with pushq (icode A, ra=1) decoding -> d_valB=0x30; reg4 reads 0x30 afterwards.
4. out_ready=0 with rmmovq (icode 4, ra=2, rb=1) in slot, then new in_valid -> in_ready=0, slot unchanged for 3 cycles; out_ready=1 -> next instruction accepted the following edge.
5. icode 1 (nop), then icode 0 (halt) -> all IDs F, valA=valB=0; write to dst F leaves the array unchanged.
6. Assert rst_n=0 mid-stall -> out_valid drops immediately without a clock edge; registers return to reset values.
